stack_alu_ext: RTL

Parametrised stack-machine ALU: an N-bit signed LIFO operand stack of configurable depth. Arithmetic ops consume the top operands and push the result back. Adds SUB, DUP and SWAP, an iterative multi-cycle multiplier with a busy/done handshake, stack status flags and error reporting. It is the next-generation replacement for the fixed-depth stack ALU in the project datapath.

---
 rtl/stack_alu_pkg.sv | 32 +++
 rtl/seq_mult.sv | 56 +++++
 rtl/stack_alu_ext.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/stack_alu_pkg.sv
// Shared opcodes, FSM state type and overflow helpers
// for the stack ALU and its multiplier.
package stack_alu_pkg;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_PUSH = 4'b0001;
   localparam logic [3:0] OP_POP  = 4'b0010;
   localparam logic [3:0] OP_DUP  = 4'b0011;
   localparam logic [3:0] OP_SWAP = 4'b0100;
   localparam logic [3:0] OP_ADD  = 4'b1000;
   localparam logic [3:0] OP_SUB  = 4'b1001;
   localparam logic [3:0] OP_MUL  = 4'b1010;

   typedef enum logic {IDLE, MUL_RUN} state_e;

   function automatic logic add_ovf(input logic sa, input logic sb,
                                    input logic sr);
      return (sa == sb) && (sr != sa);
   endfunction

   function automatic logic sub_ovf(input logic sa, input logic sb,
                                    input logic sr);
      return (sa != sb) && (sr != sa);
   endfunction

   // Product fits in N bits only if its upper N+1 bits are a pure sign run.
   function automatic logic mul_ovf(input logic hi_ones,
                                    input logic hi_zeros);
      return !(hi_ones || hi_zeros);
   endfunction

endpackage

// File: rtl/seq_mult.sv
// Iterative signed multiplier: shift-add on magnitudes,
// N iterations, sign applied to the final product.
module seq_mult #(
   parameter int N = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int IW = $clog2(N);

   logic           busy_q, neg_q;
   logic [IW-1:0]  cnt_q;
   logic [2*N-1:0] mc_q, acc_q, acc_d;
   logic [N-1:0]   mp_q, a_mag, b_mag;

   assign a_mag = a[N-1] ? -a : a;
   assign b_mag = b[N-1] ? -b : b;
   assign acc_d = acc_q + (mp_q[0] ? mc_q : '0);

   // done and product are combinational so the caller commits on the last iteration edge
   assign busy    = busy_q;
   assign done    = busy_q && (cnt_q == IW'(N - 1));
   assign product = neg_q ? -acc_d : acc_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= 1'b0;
         neg_q  <= 1'b0;
         cnt_q  <= '0;
         mc_q   <= '0;
         mp_q   <= '0;
         acc_q  <= '0;
      end else if (start) begin
         busy_q <= 1'b1;
         neg_q  <= a[N-1] ^ b[N-1];
         cnt_q  <= '0;
         mc_q   <= {{N{1'b0}}, a_mag};
         mp_q   <= b_mag;
         acc_q  <= '0;
      end else if (busy_q) begin
         acc_q <= acc_d;
         mc_q  <= mc_q << 1;
         mp_q  <= mp_q >> 1;
         cnt_q <= cnt_q + IW'(1);
         if (done) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/stack_alu_ext.sv
// Signed LIFO operand-stack ALU with SUB/DUP/SWAP,
// a multi-cycle MUL, status flags and error pulses.
module stack_alu_ext
   import stack_alu_pkg::*;
#(
   parameter int N     = 16,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N-1:0]               input_data,
   input  logic [3:0]                 opcode,
   input  logic                       op_valid,
   output logic                       busy,
   output logic                       done,
   output logic [N-1:0]               output_data,
   output logic                       overflow,
   output logic                       error,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH + 1);

   state_e         state_q, state_d;
   logic [N-1:0]   stk_q [DEPTH];
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   out_q, out_d;
   logic           ovf_q, ovf_d, err_q, err_d, done_q, done_d;
   logic           full_q, empty_q;
   logic [N-1:0]   tos, nos, sum, dif;
   logic           we0, we1;
   logic [CW-1:0]  wa0, wa1;
   logic [N-1:0]   wd0, wd1;
   logic           accept, two, mul_go;
   logic           m_busy, m_done;
   logic [2*N-1:0] m_prod;
   logic [N:0]     m_hi;

   always_comb begin
      tos = '0;
      nos = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i + 1) == cnt_q) tos = stk_q[i];
         if (CW'(i + 2) == cnt_q) nos = stk_q[i];
      end
   end

   assign sum    = nos + tos;
   assign dif    = nos - tos;
   assign two    = cnt_q >= CW'(2);
   assign accept = op_valid && (state_q == IDLE);
   assign mul_go = accept && (opcode == OP_MUL) && two;
   assign m_hi   = m_prod[2*N-1:N-1];

   seq_mult #(.N(N)) u_mult (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_go),
      .a       (nos),
      .b       (tos),
      .busy    (m_busy),
      .done    (m_done),
      .product (m_prod)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         out_q   <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
         done_q  <= done_d;
         full_q  <= (cnt_d == CW'(DEPTH));
         empty_q <= (cnt_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (we0 && wa0 == CW'(i)) stk_q[i] <= wd0;
         if (we1 && wa1 == CW'(i)) stk_q[i] <= wd1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (mul_go) state_d = MUL_RUN;
         MUL_RUN: if (m_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      out_d  = out_q;
      ovf_d  = ovf_q;
      err_d  = 1'b0;
      done_d = 1'b0;
      we0    = 1'b0;
      we1    = 1'b0;
      wa0    = cnt_q;
      wa1    = cnt_q - CW'(2);
      wd0    = '0;
      wd1    = tos;
      if (state_q == MUL_RUN) begin
         if (m_done) begin
            we0    = 1'b1;
            wa0    = cnt_q - CW'(2);
            wd0    = m_prod[N-1:0];
            cnt_d  = cnt_q - CW'(1);
            out_d  = m_prod[N-1:0];
            ovf_d  = mul_ovf(&m_hi, ~|m_hi);
            done_d = 1'b1;
         end
      end else if (accept) begin
         done_d = 1'b1;
         unique case (opcode)
            OP_NOP: ;
            OP_PUSH: begin
               if (full_q) err_d = 1'b1;
               else begin
                  we0   = 1'b1;
                  wd0   = input_data;
                  cnt_d = cnt_q + CW'(1);
                  out_d = input_data;
               end
            end
            OP_POP: begin
               if (empty_q) err_d = 1'b1;
               else begin
                  cnt_d = cnt_q - CW'(1);
                  out_d = tos;
               end
            end
            OP_DUP: begin
               if (full_q || empty_q) err_d = 1'b1;
               else begin
                  we0   = 1'b1;
                  wd0   = tos;
                  cnt_d = cnt_q + CW'(1);
                  out_d = tos;
               end
            end
            OP_SWAP: begin
               if (!two) err_d = 1'b1;
               else begin
                  we0   = 1'b1;
                  we1   = 1'b1;
                  wa0   = cnt_q - CW'(1);
                  wd0   = nos;
                  out_d = nos;
               end
            end
            OP_ADD, OP_SUB: begin
               if (!two) err_d = 1'b1;
               else begin
                  we0   = 1'b1;
                  wa0   = cnt_q - CW'(2);
                  wd0   = (opcode == OP_ADD) ? sum : dif;
                  cnt_d = cnt_q - CW'(1);
                  out_d = wd0;
                  ovf_d = (opcode == OP_ADD)
                        ? add_ovf(nos[N-1], tos[N-1], sum[N-1])
                        : sub_ovf(nos[N-1], tos[N-1], dif[N-1]);
               end
            end
            OP_MUL: begin
               if (!two) err_d = 1'b1;
               else done_d = 1'b0;
            end
            default: err_d = 1'b1;
         endcase
      end
   end

   assign busy        = m_busy;
   assign done        = done_q;
   assign output_data = out_q;
   assign overflow    = ovf_q;
   assign error       = err_q;
   assign full        = full_q;
   assign empty       = empty_q;
   assign count       = cnt_q;

endmodule
